// File: rtl/rfphoenix_vec_alu_seq.sv
// Sequential vector ALU: operates on NPASS lanes per cycle over NLANES lanes with a valid/ready result handshake.
// Optional macro RFPHOENIX_VALU_CMPPACK_EN packs CMPLTU results into lane 0 as a bit mask.
module rfphoenix_vec_alu_seq #(
    parameter int NLANES = 16,
    parameter int LW     = 32,
    parameter int NPASS  = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [2:0]           op_i,
    input  logic                 pack_i,
    input  logic [NLANES*LW-1:0] a_i,
    input  logic [NLANES*LW-1:0] b_i,
    input  logic [LW-1:0]        imm_i,
    input  logic                 flush_i,
    output logic                 busy_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [NLANES*LW-1:0] o
);

    localparam int W   = NLANES * LW;
    localparam int C   = NLANES / NPASS;
    localparam int KW  = (C > 1) ? $clog2(C) : 1;
    localparam int LGN = $clog2(NLANES);

    generate
        if (NPASS < 1 || (NLANES % NPASS) != 0) begin : g_bad_npass
            $error("rfphoenix_vec_alu_seq: NPASS=%0d must divide NLANES=%0d", NPASS, NLANES);
        end
        if (NLANES < 2 || NLANES > 64 || (NLANES & (NLANES - 1)) != 0) begin : g_bad_nlanes
            $error("rfphoenix_vec_alu_seq: NLANES=%0d must be a power of two in 2..64", NLANES);
        end
        if (LW < 8) begin : g_bad_lw
            $error("rfphoenix_vec_alu_seq: LW=%0d must be at least 8", LW);
        end
`ifdef RFPHOENIX_VALU_CMPPACK_EN
        if (NLANES > LW) begin : g_bad_pack
            $error("rfphoenix_vec_alu_seq: packed compare needs NLANES=%0d <= LW=%0d", NLANES, LW);
        end
`endif
    endgenerate

    typedef enum logic [2:0] {
        OP_ADD    = 3'd0,
        OP_SUB    = 3'd1,
        OP_AND    = 3'd2,
        OP_OR     = 3'd3,
        OP_XOR    = 3'd4,
        OP_CMPLTU = 3'd5,
        OP_VSHUF  = 3'd6,
        OP_VEX    = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e          state;
    logic [KW-1:0]   k;
    op_e             op_q;
    logic            pack_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [LGN-1:0]  imm_q;

    logic            accept;
    logic            last_chunk;
    logic            pack_mode;
    logic [NPASS*LW-1:0] chunk_res;
    logic [NPASS-1:0]    chunk_cmp;

    // Only the lane-select bits of the immediate matter; the rest are sunk here.
    logic            imm_hi_unused;
    assign imm_hi_unused = ^imm_i[LW-1:LGN];

    // One lane of result, computed from the latched operands.
    function automatic logic [LW-1:0] lane_res(input op_e op, input logic [W-1:0] av,
                                               input logic [W-1:0] bv, input logic [LGN-1:0] sel,
                                               input int n);
        logic [LW-1:0]  al;
        logic [LW-1:0]  bl;
        logic [LGN-1:0] idx;
        logic [LW-1:0]  r;
        al  = av[n*LW +: LW];
        bl  = bv[n*LW +: LW];
        idx = bl[LGN-1:0];
        case (op)
            OP_ADD:    r = al + bl;
            OP_SUB:    r = al - bl;
            OP_AND:    r = al & bl;
            OP_OR:     r = al | bl;
            OP_XOR:    r = al ^ bl;
            OP_CMPLTU: r = (al < bl) ? LW'(1) : '0;
            OP_VSHUF:  r = av[int'(idx)*LW +: LW];
            default:   r = av[int'(sel)*LW +: LW];
        endcase
        return r;
    endfunction

    assign accept = start_i && !flush_i &&
                    ((state == IDLE) || ((state == DONE) && ready_i));
    assign last_chunk = (k == KW'(C - 1));

`ifdef RFPHOENIX_VALU_CMPPACK_EN
    assign pack_mode = pack_q && (op_q == OP_CMPLTU);
`else
    // pack_i is latched for interface symmetry but has no effect in this build.
    logic pack_unused;
    assign pack_unused = pack_q;
    assign pack_mode   = 1'b0;
`endif

    // NOTE: every variable written in a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        chunk_res = '0;
        chunk_cmp = '0;
        for (int j = 0; j < NPASS; j++) begin
            chunk_res[j*LW +: LW] = lane_res(op_q, a_q, b_q, imm_q, int'(k) * NPASS + j);
            chunk_cmp[j] = chunk_res[j*LW];
        end
    end

    // NOTE: operand latches are plain data registers with no reset; they are only read after an accept loads them.
    always_ff @(posedge clk_i) begin
        if (accept && !rst_i) begin
            op_q   <= op_e'(op_i);
            pack_q <= pack_i;
            a_q    <= a_i;
            b_q    <= b_i;
            imm_q  <= imm_i[LGN-1:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            k       <= '0;
            o       <= '0;
            valid_o <= 1'b0;
            busy_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= RUN;
                        k       <= '0;
                        o       <= '0;
                        busy_o  <= 1'b1;
                        valid_o <= 1'b0;
                    end
                end
                RUN: begin
                    if (flush_i) begin
                        state   <= IDLE;
                        busy_o  <= 1'b0;
                        valid_o <= 1'b0;
                    end else begin
                        if (pack_mode) begin
                            // Packed compare: chunk bits land in lane 0 at their lane index.
                            for (int j = 0; j < NPASS; j++) begin
                                o[int'(k) * NPASS + j] <= chunk_cmp[j];
                            end
                        end else begin
                            o[int'(k) * NPASS * LW +: NPASS * LW] <= chunk_res;
                        end
                        k <= k + KW'(1);
                        if (last_chunk) begin
                            state   <= DONE;
                            valid_o <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (flush_i) begin
                        state   <= IDLE;
                        busy_o  <= 1'b0;
                        valid_o <= 1'b0;
                    end else if (ready_i) begin
                        valid_o <= 1'b0;
                        if (accept) begin
                            state <= RUN;
                            k     <= '0;
                            o     <= '0;
                        end else begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    busy_o  <= 1'b0;
                    valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rfphoenix_vec_alu_seq.sv
// Randomized self-checking bench for rfphoenix_vec_alu_seq against a lane-array reference model.
module tb_rfphoenix_vec_alu_seq;

    localparam int NLANES = 16;
    localparam int LW     = 32;
    localparam int NPASS  = 4;
    localparam int W      = NLANES * LW;
    localparam int C      = NLANES / NPASS;

    logic           clk_i = 1'b0;
    logic           rst_i = 1'b1;
    logic           start_i = 1'b0;
    logic [2:0]     op_i = '0;
    logic           pack_i = 1'b0;
    logic [W-1:0]   a_i = '0;
    logic [W-1:0]   b_i = '0;
    logic [LW-1:0]  imm_i = '0;
    logic           flush_i = 1'b0;
    logic           busy_o;
    logic           valid_o;
    logic           ready_i = 1'b0;
    logic [W-1:0]   o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_o;
    bit           exp_packed;

    rfphoenix_vec_alu_seq #(.NLANES(NLANES), .LW(LW), .NPASS(NPASS)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i), .pack_i(pack_i),
        .a_i(a_i), .b_i(b_i), .imm_i(imm_i), .flush_i(flush_i), .busy_o(busy_o),
        .valid_o(valid_o), .ready_i(ready_i), .o(o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [W-1:0] rand_vec();
        logic [W-1:0] v;
        for (int i = 0; i < NLANES; i++) v[i*LW +: LW] = $urandom;
        return v;
    endfunction

    // Reference: whole-vector result from the operation rules on arrays of lanes.
    function automatic logic [W-1:0] model(input int op, input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [LW-1:0] imm, input bit pack);
        logic [LW-1:0] al [NLANES];
        logic [LW-1:0] bl [NLANES];
        logic [W-1:0]  res;
        res = '0;
        for (int n = 0; n < NLANES; n++) begin
            al[n] = a[n*LW +: LW];
            bl[n] = b[n*LW +: LW];
        end
        for (int n = 0; n < NLANES; n++) begin
            case (op)
                0: res[n*LW +: LW] = al[n] + bl[n];
                1: res[n*LW +: LW] = al[n] - bl[n];
                2: res[n*LW +: LW] = al[n] & bl[n];
                3: res[n*LW +: LW] = al[n] | bl[n];
                4: res[n*LW +: LW] = al[n] ^ bl[n];
                5: res[n*LW +: LW] = (al[n] < bl[n]) ? 1 : 0;
                6: res[n*LW +: LW] = al[bl[n] % NLANES];
                default: res[n*LW +: LW] = al[imm % NLANES];
            endcase
        end
`ifdef RFPHOENIX_VALU_CMPPACK_EN
        if (pack && op == 5) begin
            res = '0;
            for (int n = 0; n < NLANES; n++) res[n] = (al[n] < bl[n]);
        end
`else
        if (pack) res = res;
`endif
        return res;
    endfunction

    function automatic logic [W-1:0] low_mask(input int nbits);
        logic [W-1:0] m;
        for (int i = 0; i < W; i++) m[i] = (i < nbits);
        return m;
    endfunction

    // Expected o after `chunks` chunks have been written.
    function automatic logic [W-1:0] partial(input int chunks);
        return exp_o & low_mask(exp_packed ? chunks * NPASS : chunks * NPASS * LW);
    endfunction

    // Accept an operation (from IDLE, or back-to-back from DONE with ready), then scramble inputs.
    task automatic launch(input int op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [LW-1:0] imm, input bit pack);
        start_i = 1'b1; ready_i = 1'b1; flush_i = 1'b0;
        op_i = 3'(op); a_i = a; b_i = b; imm_i = imm; pack_i = pack;
        exp_o = model(op, a, b, imm, pack);
`ifdef RFPHOENIX_VALU_CMPPACK_EN
        exp_packed = pack && (op == 5);
`else
        exp_packed = 1'b0;
`endif
        step();
        start_i = 1'b0; ready_i = 1'b0;
        op_i = 3'($urandom); a_i = rand_vec(); b_i = rand_vec(); imm_i = $urandom; pack_i = 1'($urandom);
        check("accept_busy", W'(busy_o), W'(1));
        check("accept_valid", W'(valid_o), W'(0));
        check("accept_clear", o, '0);
    endtask

    task automatic run_chunks(input int nchunks);
        for (int c = 0; c < nchunks; c++) begin
            start_i = 1'($urandom);
            ready_i = 1'($urandom);
            a_i = rand_vec();
            step();
            check("chunk_o", o, partial(c + 1));
            check("chunk_valid", W'(valid_o), W'(c == C - 1));
            check("chunk_busy", W'(busy_o), W'(1));
        end
        start_i = 1'b0; ready_i = 1'b0;
    endtask

    task automatic hold(input int n);
        ready_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            start_i = 1'($urandom);
            step();
            check("hold_valid", W'(valid_o), W'(1));
            check("hold_o", o, exp_o);
            check("hold_busy", W'(busy_o), W'(1));
        end
        start_i = 1'b0;
    endtask

    task automatic release_result();
        start_i = 1'b0; ready_i = 1'b1;
        step();
        ready_i = 1'b0;
        check("release_busy", W'(busy_o), W'(0));
        check("release_valid", W'(valid_o), W'(0));
    endtask

    logic [W-1:0] va, vb, snap;

    initial begin
        // Reset, with other inputs active to prove reset overrides them.
        start_i = 1'b1; ready_i = 1'b1;
        step(); step();
        check("rst_o", o, '0);
        check("rst_valid", W'(valid_o), W'(0));
        check("rst_busy", W'(busy_o), W'(0));
        start_i = 1'b0; ready_i = 1'b0; rst_i = 1'b0;
        step();
        check("idle_busy", W'(busy_o), W'(0));

        // ADD with wraparound.
        for (int n = 0; n < NLANES; n++) begin
            va[n*LW +: LW] = LW'(n);
            vb[n*LW +: LW] = 32'hFFFF_FFFF;
        end
        launch(0, va, vb, '0, 1'b0);
        run_chunks(C);
        check("add_lane0", W'(o[31:0]), W'(32'hFFFF_FFFF));
        check("add_lane9", W'(o[9*LW +: LW]), W'(32'd8));
        release_result();

        // VSHUF and VEX.
        for (int n = 0; n < NLANES; n++) begin
            va[n*LW +: LW] = LW'(32'h100 + n);
            vb[n*LW +: LW] = LW'(15 - n + 16);
        end
        launch(6, va, vb, '0, 1'b0);
        run_chunks(C);
        check("vshuf_lane3", W'(o[3*LW +: LW]), W'(32'h10C));
        release_result();
        launch(7, va, vb, 32'h23, 1'b0);
        run_chunks(C);
        check("vex_lane11", W'(o[11*LW +: LW]), W'(32'h103));
        release_result();

        // CMPLTU with pack requested.
        for (int n = 0; n < NLANES; n++) begin
            va[n*LW +: LW] = LW'(n);
            vb[n*LW +: LW] = 32'd8;
        end
        launch(5, va, vb, '0, 1'b1);
        run_chunks(C);
`ifdef RFPHOENIX_VALU_CMPPACK_EN
        check("cmp_pack_lane0", W'(o[31:0]), W'(32'hFF));
        check("cmp_pack_lane1", W'(o[1*LW +: LW]), W'(0));
`else
        check("cmp_lane7", W'(o[7*LW +: LW]), W'(1));
        check("cmp_lane8", W'(o[8*LW +: LW]), W'(0));
`endif

        // Hold with ready low, then back-to-back accept.
        hold(5);
        launch(1, rand_vec(), rand_vec(), '0, 1'b0);
        run_chunks(C);
        release_result();

        // Flush after two chunks, with start and ready also asserted.
        launch(4, rand_vec(), rand_vec(), '0, 1'b0);
        run_chunks(2);
        flush_i = 1'b1; start_i = 1'b1; ready_i = 1'b1;
        step();
        check("flush_busy", W'(busy_o), W'(0));
        check("flush_valid", W'(valid_o), W'(0));
        check("flush_o", o, partial(2));
        // Flush in IDLE: simultaneous start ignored.
        step();
        check("idle_flush_busy", W'(busy_o), W'(0));
        check("idle_flush_o", o, partial(2));
        flush_i = 1'b0; start_i = 1'b0; ready_i = 1'b0;
        for (int i = 0; i < C + 1; i++) begin
            step();
            check("post_flush_valid", W'(valid_o), W'(0));
        end

        // Flush in DONE keeps the result.
        launch(2, rand_vec(), rand_vec(), '0, 1'b0);
        run_chunks(C);
        snap = exp_o;
        flush_i = 1'b1; ready_i = 1'b1; start_i = 1'b1;
        step();
        flush_i = 1'b0; ready_i = 1'b0; start_i = 1'b0;
        check("done_flush_valid", W'(valid_o), W'(0));
        check("done_flush_busy", W'(busy_o), W'(0));
        check("done_flush_o", o, snap);

        // Reset in DONE and mid-RUN.
        launch(3, rand_vec(), rand_vec(), '0, 1'b0);
        run_chunks(C);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check("rst_done_o", o, '0);
        check("rst_done_valid", W'(valid_o), W'(0));
        check("rst_done_busy", W'(busy_o), W'(0));
        launch(0, rand_vec(), rand_vec(), '0, 1'b0);
        run_chunks(1);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check("rst_run_o", o, '0);
        for (int i = 0; i < C + 1; i++) begin
            step();
            check("rst_run_valid", W'(valid_o), W'(0));
        end

        // Randomized operations, mixing release and back-to-back accepts.
        for (int it = 0; it < 40; it++) begin
            int op;
            op = int'($urandom_range(0, 7));
            va = rand_vec();
            vb = rand_vec();
            if (op == 5 || op == 6) begin
                for (int n = 0; n < NLANES; n++)
                    if ($urandom_range(0, 1) == 1) vb[n*LW +: LW] = va[n*LW +: LW] + LW'($urandom_range(0, 3)) - LW'(1);
            end
            launch(op, va, vb, $urandom, 1'($urandom));
            run_chunks(C);
            hold(int'($urandom_range(0, 2)));
            if ($urandom_range(0, 1) == 1) release_result();
        end
        release_result();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
